// File: rtl/sdp_wdma_writer_if.sv
// ----------------------------------------------------------------------------
// sdp_wdma_writer_if : SDP output atom stream and DMA write request/ack bundle
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface sdp_wdma_writer_if;
  logic [255:0] dp2wdma_pd;
  logic         dp2wdma_valid;
  logic         dp2wdma_ready;
  logic [514:0] dma_wr_req_pd;
  logic         dma_wr_req_valid;
  logic         dma_wr_req_ready;
  logic         dma_wr_rsp_complete;

  modport master (
    input  dp2wdma_pd,
    input  dp2wdma_valid,
    output dp2wdma_ready,
    output dma_wr_req_pd,
    output dma_wr_req_valid,
    input  dma_wr_req_ready,
    input  dma_wr_rsp_complete
  );

  modport slave (
    output dp2wdma_pd,
    output dp2wdma_valid,
    input  dp2wdma_ready,
    input  dma_wr_req_pd,
    input  dma_wr_req_valid,
    output dma_wr_req_ready,
    output dma_wr_rsp_complete
  );
endinterface

`default_nettype wire

// File: rtl/sdp_wdma_writer.sv
// ----------------------------------------------------------------------------
// sdp_wdma_writer : packs SDP output atoms into DMA write cmd/data packets
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sdp_wdma_writer #(
  parameter int AW    = 64,
  parameter int SIZEW = 13
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic                 op_load,
  input  logic [12:0]          reg2dp_channel,
  input  logic [12:0]          reg2dp_height,
  input  logic [12:0]          reg2dp_width,
  input  logic [1:0]           reg2dp_out_precision,
  input  logic [31:0]          reg2dp_dst_base_addr_high,
  input  logic [26:0]          reg2dp_dst_base_addr_low,
  input  logic [26:0]          reg2dp_dst_line_stride,
  input  logic [26:0]          reg2dp_dst_surface_stride,
  input  logic                 reg2dp_perf_dma_en,
  sdp_wdma_writer_if.master    bus,
  output logic                 wdma_done,
  output logic [31:0]          dp2reg_wdma_stall
);

  localparam int PD_W = 515;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CMD      = 2'd1,
    DATA     = 2'd2,
    WAIT_ACK = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [12:0]       height_q, height_d;
  logic [12:0]       width_q, width_d;
  logic [9:0]        surf_num_q, surf_num_d;
  logic [31:0]       base_high_q, base_high_d;
  logic [31:0]       line_stride_q, line_stride_d;
  logic [31:0]       surf_stride_q, surf_stride_d;
  logic [12:0]       line_cnt_q, line_cnt_d;
  logic [9:0]        surf_cnt_q, surf_cnt_d;
  logic [12:0]       atom_cnt_q, atom_cnt_d;
  logic [31:0]       line_addr_q, line_addr_d;
  logic [31:0]       surf_addr_q, surf_addr_d;
  logic              hold_q, hold_d;
  logic [255:0]      hold_pd_q, hold_pd_d;
  logic              ack_q, ack_d;
  logic              out_valid_q, out_valid_d;
  logic [PD_W-1:0]   out_pd_q, out_pd_d;
  logic              done_q, done_d;
  logic [31:0]       stall_q, stall_d;

  logic              out_free;
  logic              out_load;
  logic              last_line;
  logic              last_surf;
  logic              last_atom;
  logic [AW-1:0]     line_byte_addr;
  logic [PD_W-1:0]   cmd_pd;
  logic [9:0]        cfg_surf_num;
  logic              w_unused_ch;

  // Low channel bits only select a position inside an atom, never a surface.
  assign w_unused_ch = ^reg2dp_channel[3:0];

  assign cfg_surf_num = (reg2dp_out_precision == 2'd0)
                      ? ({2'b00, reg2dp_channel[12:5]} + 10'd1)
                      : ({1'b0,  reg2dp_channel[12:4]} + 10'd1);

  assign out_free       = ~out_valid_q | bus.dma_wr_req_ready;
  assign last_line      = (line_cnt_q == height_q);
  assign last_surf      = (surf_cnt_q == (surf_num_q - 10'd1));
  assign last_atom      = (atom_cnt_q == width_q);
  assign line_byte_addr = AW'({base_high_q, 32'b0}) + AW'({line_addr_q, 5'b0});

  always_comb begin
    cmd_pd                     = '0;
    cmd_pd[AW-1:0]             = line_byte_addr;
    cmd_pd[AW +: SIZEW]        = SIZEW'(width_q);
    cmd_pd[AW+SIZEW]           = last_line & last_surf;
  end

  always_comb begin
    state_d       = state_q;
    height_d      = height_q;
    width_d       = width_q;
    surf_num_d    = surf_num_q;
    base_high_d   = base_high_q;
    line_stride_d = line_stride_q;
    surf_stride_d = surf_stride_q;
    line_cnt_d    = line_cnt_q;
    surf_cnt_d    = surf_cnt_q;
    atom_cnt_d    = atom_cnt_q;
    line_addr_d   = line_addr_q;
    surf_addr_d   = surf_addr_q;
    hold_d        = hold_q;
    hold_pd_d     = hold_pd_q;
    ack_d         = ack_q | ((state_q != IDLE) & bus.dma_wr_rsp_complete);
    out_pd_d      = out_pd_q;
    out_load      = 1'b0;
    done_d        = 1'b0;
    stall_d       = stall_q;
    bus.dp2wdma_ready = 1'b0;

    if (reg2dp_perf_dma_en && out_valid_q && !bus.dma_wr_req_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end

    case (state_q)
      IDLE: begin
        if (op_load) begin
          height_d      = reg2dp_height;
          width_d       = reg2dp_width;
          surf_num_d    = cfg_surf_num;
          base_high_d   = reg2dp_dst_base_addr_high;
          line_stride_d = {5'b0, reg2dp_dst_line_stride};
          surf_stride_d = {5'b0, reg2dp_dst_surface_stride};
          line_addr_d   = {5'b0, reg2dp_dst_base_addr_low};
          surf_addr_d   = {5'b0, reg2dp_dst_base_addr_low};
          line_cnt_d    = '0;
          surf_cnt_d    = '0;
          atom_cnt_d    = '0;
          hold_d        = 1'b0;
          ack_d         = 1'b0;
          stall_d       = '0;
          state_d       = CMD;
        end
      end
      CMD: begin
        if (out_free) begin
          out_load   = 1'b1;
          out_pd_d   = cmd_pd;
          atom_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        bus.dp2wdma_ready = out_free;
        if (out_free && bus.dp2wdma_valid) begin
          atom_cnt_d = atom_cnt_q + 13'd1;
          if (hold_q) begin
            out_load = 1'b1;
            out_pd_d = {1'b1, 2'b11, bus.dp2wdma_pd, hold_pd_q};
            hold_d   = 1'b0;
          end else if (last_atom) begin
            out_load = 1'b1;
            out_pd_d = {1'b1, 2'b01, 256'b0, bus.dp2wdma_pd};
          end else begin
            hold_d    = 1'b1;
            hold_pd_d = bus.dp2wdma_pd;
          end
          if (last_atom) begin
            if (last_line && last_surf) begin
              state_d = WAIT_ACK;
            end else begin
              state_d = CMD;
              if (last_line) begin
                line_cnt_d  = '0;
                surf_cnt_d  = surf_cnt_q + 10'd1;
                surf_addr_d = surf_addr_q + surf_stride_q;
                line_addr_d = surf_addr_q + surf_stride_q;
              end else begin
                line_cnt_d  = line_cnt_q + 13'd1;
                line_addr_d = line_addr_q + line_stride_q;
              end
            end
          end
        end
      end
      WAIT_ACK: begin
        // Final packet has drained once the output register is empty here.
        if (!out_valid_q && ack_q) begin
          done_d  = 1'b1;
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = out_free ? out_load : out_valid_q;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q       <= IDLE;
      height_q      <= '0;
      width_q       <= '0;
      surf_num_q    <= '0;
      base_high_q   <= '0;
      line_stride_q <= '0;
      surf_stride_q <= '0;
      line_cnt_q    <= '0;
      surf_cnt_q    <= '0;
      atom_cnt_q    <= '0;
      line_addr_q   <= '0;
      surf_addr_q   <= '0;
      hold_q        <= 1'b0;
      hold_pd_q     <= '0;
      ack_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_pd_q      <= '0;
      done_q        <= 1'b0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      height_q      <= height_d;
      width_q       <= width_d;
      surf_num_q    <= surf_num_d;
      base_high_q   <= base_high_d;
      line_stride_q <= line_stride_d;
      surf_stride_q <= surf_stride_d;
      line_cnt_q    <= line_cnt_d;
      surf_cnt_q    <= surf_cnt_d;
      atom_cnt_q    <= atom_cnt_d;
      line_addr_q   <= line_addr_d;
      surf_addr_q   <= surf_addr_d;
      hold_q        <= hold_d;
      hold_pd_q     <= hold_pd_d;
      ack_q         <= ack_d;
      out_valid_q   <= out_valid_d;
      out_pd_q      <= out_pd_d;
      done_q        <= done_d;
      stall_q       <= stall_d;
    end
  end

  assign bus.dma_wr_req_valid = out_valid_q;
  assign bus.dma_wr_req_pd    = out_pd_q;
  assign wdma_done            = done_q;
  assign dp2reg_wdma_stall    = stall_q;

endmodule

`default_nettype wire
